// File: rtl/pattern_scheduler_if.sv
// Bus bundle for pattern_scheduler: playback controls, playlist config port,
// pattern generator inputs and LED-driver facing outputs.
// master = the block feeding the scheduler, slave = the scheduler itself.
interface pattern_scheduler_if #(
    parameter int SLOT_W = 2
);
    logic              en;
    logic              skip;
    logic              hold;
    logic              cfg_we;
    logic [SLOT_W-1:0] cfg_addr;
    logic [2:0]        cfg_pat;
    logic [6:0]        cfg_dur;
    logic [127:0]      pat_leds;
    logic [15:0]       led;
    logic [SLOT_W-1:0] cur_slot;
    logic              playing;
    logic              slot_done;

    modport master (
        output en, skip, hold, cfg_we, cfg_addr, cfg_pat, cfg_dur, pat_leds,
        input  led, cur_slot, playing, slot_done
    );

    modport slave (
        input  en, skip, hold, cfg_we, cfg_addr, cfg_pat, cfg_dur, pat_leds,
        output led, cur_slot, playing, slot_done
    );
endinterface

// File: rtl/pattern_scheduler.sv
// Playlist scheduler for the LED-fan display. Plays up to NUM_SLOTS slots,
// each selecting one of 8 pattern generator words for dur seconds, with an
// optional blank gap between slots, plus skip / hold / enable controls.
// Optional feature: define PATTERN_SCHED_FADE_EN to gate led with a 25% PWM
// during the last second of every slot (fade-out cue).
//
// state | meaning
// IDLE  | output blank, waiting for en and an enabled slot
// PLAY  | showing the current slot's pattern, slot timer running
// GAP   | blank output for GAP_CYC cycles before the next slot
module pattern_scheduler #(
    parameter int CLK_HZ    = 100000000,
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int GAP_CYC   = 0,
    parameter int DEF_DUR   = 10
) (
    input  logic               clk,
    input  logic               rst,
    pattern_scheduler_if.slave bus
);
    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        pat_tab [NUM_SLOTS];
    logic [6:0]        dur_tab [NUM_SLOTS];
    logic [SLOT_W-1:0] cur_slot, slot_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic [6:0]        elapsed;
    logic [GAP_W-1:0]  gap_cnt;
    logic              slot_done;
    logic [2:0]        cur_pat;
    logic [6:0]        cur_dur;
    logic              sec_tick, dur_reached, slot_end;
    logic              enter_slot, done_nxt;
    logic              first_ok, next_ok;
    logic [SLOT_W-1:0] first_idx, next_idx;
    logic [15:0]       play_word;

    assign cur_pat     = pat_tab[cur_slot];
    assign cur_dur     = dur_tab[cur_slot];
    assign sec_tick    = (state == PLAY) && !bus.hold && (tick_cnt == TICK_LAST);
    // Compared one bit wider so a saturated elapsed of 127 still ends any slot.
    assign dur_reached = ({1'b0, elapsed} + 8'd1) >= {1'b0, cur_dur};
    assign slot_end    = (state == PLAY) && (bus.skip || (sec_tick && dur_reached));
    assign play_word   = bus.pat_leds[{cur_pat, 4'b0000} +: 16];

    // Playlist table: defaults on reset, one slot rewritten per cfg strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pat_tab[i] <= 3'(i);
                dur_tab[i] <= 7'(DEF_DUR);
            end
        end else if (bus.cfg_we) begin
            pat_tab[bus.cfg_addr] <= bus.cfg_pat;
            dur_tab[bus.cfg_addr] <= bus.cfg_dur;
        end
    end

    // Lowest-index enabled slot, used when starting from IDLE.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (dur_tab[i] != 7'd0) begin
                first_ok  = 1'b1;
                first_idx = SLOT_W'(i);
            end
        end
    end

    // First enabled slot after cur_slot, wrapping round to cur_slot itself.
    always_comb begin
        next_ok  = 1'b0;
        next_idx = cur_slot;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            if (dur_tab[cur_slot + SLOT_W'(k)] != 7'd0) begin
                next_ok  = 1'b1;
                next_idx = cur_slot + SLOT_W'(k);
            end
        end
    end

    // Next-state decode; slot_done is only raised on a genuine slot end.
    always_comb begin
        state_nxt  = state;
        slot_nxt   = cur_slot;
        enter_slot = 1'b0;
        done_nxt   = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (first_ok) begin
                        state_nxt  = PLAY;
                        slot_nxt   = first_idx;
                        enter_slot = 1'b1;
                    end
                end
                PLAY: begin
                    if (slot_end) begin
                        done_nxt = 1'b1;
                        if (GAP_CYC > 0) begin
                            state_nxt = GAP;
                        end else if (next_ok) begin
                            slot_nxt   = next_idx;
                            enter_slot = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (next_ok) begin
                            state_nxt  = PLAY;
                            slot_nxt   = next_idx;
                            enter_slot = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, current slot and the registered slot_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_slot  <= '0;
            slot_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_slot  <= slot_nxt;
            slot_done <= done_nxt;
        end
    end

    // Slot timer: clears on every slot entry and whenever PLAY is left.
    always_ff @(posedge clk) begin
        if (rst || state != PLAY || state_nxt != PLAY || enter_slot) begin
            tick_cnt <= '0;
            elapsed  <= '0;
        end else if (sec_tick) begin
            tick_cnt <= '0;
            if (elapsed != 7'd127) elapsed <= elapsed + 7'd1;
        end else if (!bus.hold) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Gap length counter, idle at zero outside GAP.
    always_ff @(posedge clk) begin
        if (rst || state != GAP) gap_cnt <= '0;
        else                     gap_cnt <= gap_cnt + GAP_W'(1);
    end

`ifdef PATTERN_SCHED_FADE_EN
    logic final_sec, pwm_on;
    assign final_sec = ({1'b0, elapsed} + 8'd1) == {1'b0, cur_dur};
    assign pwm_on    = (({2'b00, tick_cnt} & (CNT_W + 2)'(3)) == '0);
    assign bus.led   = (state != PLAY)        ? 16'h0000 :
                       (final_sec && !pwm_on) ? 16'h0000 : play_word;
`else
    assign bus.led   = (state == PLAY) ? play_word : 16'h0000;
`endif

    assign bus.cur_slot  = cur_slot;
    assign bus.playing   = (state != IDLE);
    assign bus.slot_done = slot_done;
endmodule

// File: tb/tb_pattern_scheduler.sv
`timescale 1ns/1ps
module tb_pattern_scheduler;
    localparam int CLK_HZ  = 10;
    localparam int NS      = 4;
    localparam int SW      = 2;
    localparam int DEF_DUR = 10;
    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_GAP   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0, skip = 1'b0, hold = 1'b0, cfg_we = 1'b0;
    logic [SW-1:0]  cfg_addr = '0;
    logic [2:0]     cfg_pat = '0;
    logic [6:0]     cfg_dur = '0;
    logic [127:0]   pat_leds = '0;

    always #5 clk = ~clk;

    pattern_scheduler_if #(.SLOT_W(SW)) if0 ();
    pattern_scheduler_if #(.SLOT_W(SW)) if1 ();

    assign if0.en = en;        assign if1.en = en;
    assign if0.skip = skip;    assign if1.skip = skip;
    assign if0.hold = hold;    assign if1.hold = hold;
    assign if0.cfg_we = cfg_we;       assign if1.cfg_we = cfg_we;
    assign if0.cfg_addr = cfg_addr;   assign if1.cfg_addr = cfg_addr;
    assign if0.cfg_pat = cfg_pat;     assign if1.cfg_pat = cfg_pat;
    assign if0.cfg_dur = cfg_dur;     assign if1.cfg_dur = cfg_dur;
    assign if0.pat_leds = pat_leds;   assign if1.pat_leds = pat_leds;

    pattern_scheduler #(.CLK_HZ(CLK_HZ), .NUM_SLOTS(NS), .SLOT_W(SW), .GAP_CYC(0), .DEF_DUR(DEF_DUR))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    pattern_scheduler #(.CLK_HZ(CLK_HZ), .NUM_SLOTS(NS), .SLOT_W(SW), .GAP_CYC(3), .DEF_DUR(DEF_DUR))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic [15:0]   led;
        logic [SW-1:0] slot;
        logic          playing;
        logic          done;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int checks = 0;
    int passed = 0;
    int done_cnt[2] = '{0, 0};

    // Reference model: slot time measured as "cycles played without hold".
    int m_state[2], m_slot[2], m_played[2], m_gap_left[2];
    bit m_done[2];
    int m_pat[2][NS];
    int m_dur[2][NS];
    int gap_cyc[2] = '{0, 3};

    function automatic void m_reset(int d);
        m_state[d] = S_IDLE; m_slot[d] = 0; m_played[d] = 0;
        m_gap_left[d] = 0; m_done[d] = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_pat[d][i] = i;
            m_dur[d][i] = DEF_DUR;
        end
    endfunction

    function automatic void m_enter(int d, int s);
        m_state[d] = S_PLAY; m_slot[d] = s; m_played[d] = 0;
    endfunction

    function automatic void m_next(int d);
        for (int k = 1; k <= NS; k++) begin
            int s;
            s = (m_slot[d] + k) % NS;
            if (m_dur[d][s] != 0) begin
                m_enter(d, s);
                return;
            end
        end
        m_state[d] = S_IDLE;
    endfunction

    function automatic exp_t m_out(int d);
        exp_t e;
        logic [15:0] w;
        e.slot    = SW'(m_slot[d]);
        e.playing = (m_state[d] != S_IDLE);
        e.done    = m_done[d];
        e.led     = 16'h0000;
        if (m_state[d] == S_PLAY) begin
            w = pat_leds[16*m_pat[d][m_slot[d]] +: 16];
`ifdef PATTERN_SCHED_FADE_EN
            if ((m_played[d] / CLK_HZ) + 1 == m_dur[d][m_slot[d]] && (m_played[d] % CLK_HZ) % 4 != 0)
                w = 16'h0000;
`endif
            e.led = w;
        end
        return e;
    endfunction

    function automatic void m_step(int d);
        bit nd;
        bit tick;
        int secs;
        nd = 1'b0;
        if (rst) begin
            m_reset(d);
            return;
        end
        if (!en) begin
            m_state[d] = S_IDLE;
        end else if (m_state[d] == S_IDLE) begin
            for (int i = NS - 1; i >= 0; i--)
                if (m_dur[d][i] != 0) m_enter(d, i);
        end else if (m_state[d] == S_PLAY) begin
            tick = !hold && ((m_played[d] + 1) % CLK_HZ == 0);
            secs = (m_played[d] + 1) / CLK_HZ;
            if (skip || (tick && secs >= m_dur[d][m_slot[d]])) begin
                nd = 1'b1;
                if (gap_cyc[d] > 0) begin
                    m_state[d] = S_GAP;
                    m_gap_left[d] = gap_cyc[d];
                end else begin
                    m_next(d);
                end
            end else if (!hold) begin
                m_played[d]++;
            end
        end else begin
            m_gap_left[d]--;
            if (m_gap_left[d] == 0) m_next(d);
        end
        m_done[d] = nd;
        if (cfg_we) begin
            m_pat[d][cfg_addr] = int'(cfg_pat);
            m_dur[d][cfg_addr] = int'(cfg_dur);
        end
    endfunction

    task automatic check_out(int d, exp_t e, logic [15:0] led, logic [SW-1:0] slot, logic pl, logic dn);
        checks++;
        if (led === e.led && slot === e.slot && pl === e.playing && dn === e.done)
            passed++;
        else
            $display("FAIL dut%0d_cycle @%0t: got led=%h slot=%0d playing=%b done=%b, expected led=%h slot=%0d playing=%b done=%b",
                     d, $time, led, slot, pl, dn, e.led, e.slot, e.playing, e.done);
        if (dn === 1'b1) done_cnt[d]++;
    endtask

    task automatic check_val(string name, int act, int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Monitor: pops one predicted cycle per DUT and compares it.
    always @(negedge clk) begin
        if (exp_q0.size() > 0)
            check_out(0, exp_q0.pop_front(), if0.led, if0.cur_slot, if0.playing, if0.slot_done);
        if (exp_q1.size() > 0)
            check_out(1, exp_q1.pop_front(), if1.led, if1.cur_slot, if1.playing, if1.slot_done);
    end

    // Issue one cycle of the current inputs: predict, queue, advance model.
    task automatic step();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e = m_out(d);
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            m_step(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(int addr, int pat, int dur);
        cfg_we = 1'b1; cfg_addr = SW'(addr); cfg_pat = 3'(pat); cfg_dur = 7'(dur);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int en_low;
        en_low = 0;
        for (int p = 0; p < 8; p++) pat_leds[16*p +: 16] = 16'(16'h1111 * p);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_reset(0);
        m_reset(1);
        rst = 1'b0;
        en  = 1'b1;

        // Default playlist, four 100-cycle slots, wrap back to slot 0.
        repeat (450) step();
        check_val("p1_done_count_gap0", done_cnt[0], 4);
        check_val("p1_done_count_gap3", done_cnt[1], 4);
        check_val("p1_wrap_slot_gap0", int'(if0.cur_slot), 0);
        check_val("p1_wrap_slot_gap3", int'(if1.cur_slot), 0);
        check_val("p1_playing_gap0", int'(if0.playing), 1);

        // Slot 1 disabled, slot 2 shortened.
        reset_pulse();
        cfg_write(1, 1, 0);
        cfg_write(2, 2, 2);
        repeat (400) step();

        // Skip, hold and enable drop.
        reset_pulse();
        repeat (5) step();
        skip = 1'b1; step(); skip = 1'b0;
        repeat (20) step();
        hold = 1'b1; repeat (37) step(); hold = 1'b0;
        repeat (150) step();
        en = 1'b0; repeat (3) step();
        check_val("en_low_playing_gap0", int'(if0.playing), 0);
        check_val("en_low_led_gap3", int'(if1.led), 0);
        en = 1'b1;
        repeat (30) step();

        // Randomised controls, config writes, pattern changes and resets.
        for (int n = 0; n < 3000; n++) begin
            if (en_low > 0) begin
                en = 1'b0;
                en_low--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 149) == 0) en_low = $urandom_range(1, 5);
            end
            skip = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 29) == 0) hold = ~hold;
            cfg_we   = ($urandom_range(0, 39) == 0);
            cfg_addr = SW'($urandom_range(0, NS - 1));
            cfg_pat  = 3'($urandom_range(0, 7));
            cfg_dur  = 7'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                pat_leds[16*$urandom_range(0, 7) +: 16] = 16'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0; en = 1'b1; hold = 1'b0; skip = 1'b0; cfg_we = 1'b0;

        // Disable every slot while playing, then re-enable only slot 3.
        for (int i = 0; i < NS; i++) cfg_write(i, i, 0);
        repeat (40) step();
        check_val("all_off_playing_gap0", int'(if0.playing), 0);
        check_val("all_off_playing_gap3", int'(if1.playing), 0);
        check_val("all_off_led_gap0", int'(if0.led), 0);
        cfg_write(3, 5, 1);
        repeat (35) step();
        check_val("single_slot_gap0", int'(if0.cur_slot), 3);
        check_val("single_slot_gap3", int'(if1.cur_slot), 3);
        check_val("single_playing_gap0", int'(if0.playing), 1);

        #10;
        check_val("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Playlist scheduler for the LED-fan display.
- Selects one of 8 pattern generators' 16-bit LED words. Smile, cute, playboy, dim and similar generators all feed in.
- Plays them in a programmable sequence of slots, each with a duration in seconds.
- Inserts a blanking gap between slots and supports skip and hold controls. Sits between the pattern generators and the LED driver.

Parameters:
- CLK_HZ, 100000000, clk cycles per second tick. Benches use a small value.
- NUM_SLOTS, 4, number of playlist slots. Power of two, 2..8.
- SLOT_W, $clog2(NUM_SLOTS), width of the slot index.
- GAP_CYC, 0, clk cycles of blank output between slots. 0 means no gap.
- DEF_DUR, 10, reset duration in seconds for every slot.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- en, in, 1, playback enable (level).
- skip, in, 1, single-cycle pulse: end the current slot now.
- hold, in, 1, level: freeze the slot timer.
- cfg_we, in, 1, playlist write strobe.
- cfg_addr, in, SLOT_W, slot index to write.
- cfg_pat, in, 3, pattern id for the slot.
- cfg_dur, in, 7, slot duration in seconds, 0..127. 0 disables the slot.
- pat_leds, in, 128, pattern p occupies bits [16p+15:16p].
- led, out, 16, selected LED word.
- cur_slot, out, SLOT_W, slot currently playing.
- playing, out, 1, high in PLAY or GAP.
- slot_done, out, 1, one-cycle pulse when a slot ends.

Behaviour:
- Reset:
  - state=IDLE; led=0; cur_slot=0; playing=0; slot_done=0.
  - Tick counter=0; elapsed=0; gap counter=0.
  - Slot i table entry: pat=i, dur=DEF_DUR.
- Tick: counter runs 0..CLK_HZ-1 in PLAY when hold=0. sec_tick is asserted on the cycle the counter equals CLK_HZ-1; the counter then wraps to 0. Counter and elapsed clear on every slot entry, so each slot lasts exactly dur*CLK_HZ cycles.
- States:
  - IDLE:
    - led=0.
    - If en=1 and any slot has dur!=0: next cycle enter PLAY at the lowest-index slot with dur!=0.
    - Otherwise stay.
  - PLAY:
    - led=pat_leds[16*pat(cur_slot) +:16], combinational from the table and pat_leds.
    - On sec_tick, elapsed increments; 7-bit, saturates at 127.
    - Slot end is sec_tick with elapsed+1>=dur, or skip=1.
    - On slot end: slot_done=1 for one cycle (registered, coincides with the transition).
    - Then go to GAP if GAP_CYC>0, else directly to the next slot.
  - GAP:
    - led=0 for exactly GAP_CYC cycles, then enter the next slot.
    - skip during GAP is ignored.
- Next slot: search cur_slot+1, +2, … modulo NUM_SLOTS, at most NUM_SLOTS entries including cur_slot itself, for the first entry with dur!=0.
  - If none is found (all disabled by config writes), go to IDLE.
  - With a single valid slot, that slot replays.
- en=0 in any state: next cycle IDLE, led=0, playing=0. No slot_done pulse.
- hold=1 freezes the tick counter and elapsed. led still follows the live pat_leds word; skip is still honoured.
- skip and tick-end in the same cycle: one advance only, one slot_done pulse.
- Config writes:
  - Accepted in any state, take effect the next cycle.
  - A pat write to cur_slot changes led next cycle.
  - A dur write to cur_slot is re-evaluated at the next sec_tick; if the new dur<=elapsed+1, the slot ends there.
  - Writing dur=0 to cur_slot ends it at its next sec_tick.
  - cfg_we coincident with rst is ignored.
- rst mid-operation overrides everything and restores the table defaults.

Optional Feature:
- Macro: PATTERN_SCHED_FADE_EN.
- When defined: during the final second of each slot (elapsed+1==dur), led is ANDed with a 25% duty PWM. The PWM is high when tick counter[1:0]==0, giving a fade-out cue. GAP and IDLE are unaffected.
- When undefined: led is unmodified throughout PLAY, and no PWM logic is present.

Test Plan:
- Config CLK_HZ=10, GAP_CYC=0, defaults (dur=10), en=1. Pattern p word = 16'h1111*p → led=0000 for 100 cycles, then 1111, then 2222, then 3333, then 0000 again (slot wrap); slot_done pulses every 100 cycles.
- Write slot1 dur=0 and slot2 dur=2, GAP_CYC=3 → sequence slot0 (100 cyc), 3 cycles led=0, slot2 (20 cyc), 3 cycles gap, slot3.
- Pulse skip 5 cycles into slot0 → slot_done next cycle, cur_slot=1; skip coincident with the tick-end of slot1 → exactly one advance, to slot2.
- hold=1 for 37 cycles mid slot0 → slot0 lasts 137 cycles; en=0 mid slot → led=0, playing=0 next cycle, no slot_done.
- Write dur=0 to all slots while playing → IDLE after the current slot's next tick, led=0. Then write slot3 dur=1 with en=1 → PLAY slot3 and replays slot3 every 10 cycles.
- With PATTERN_SCHED_FADE_EN, dur=2, pattern FFFF → cycles 0-9 led=FFFF; cycles 10-19 led=FFFF only when counter[1:0]==0, else 0000.
